strobe_decode_arbiter: RTL

//  Round-robin arbiter and strobe sequencer for one half of a 2-to-4 select decoder (74S139 class).

---
 rtl/strobe_decode_arbiter_if.sv | 12 +
 rtl/strobe_decode_arbiter.sv | 78 +++++++
 2 files changed

// File: rtl/strobe_decode_arbiter_if.sv
// strobe_decode_arbiter_if: client request/ack lines plus decoder select/enable drive
interface strobe_decode_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] ack;
    logic       busy;
    logic       sel_a;
    logic       sel_b;
    logic       sel_g_n;
    modport master (output req, input grant, ack, busy, sel_a, sel_b, sel_g_n);
    modport slave  (input req, output grant, ack, busy, sel_a, sel_b, sel_g_n);
endinterface

// File: rtl/strobe_decode_arbiter.sv
// strobe_decode_arbiter: round-robin share of a 2-to-4 decoder half with setup/strobe/hold enable timing
module strobe_decode_arbiter #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int CNT_W      = 4
) (
    input logic clk,
    input logic reset_n,
    strobe_decode_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC  > 0 ? SETUP_CYC  - 1 : 0);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC > 0 ? STROBE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC   > 0 ? HOLD_CYC   - 1 : 0);
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0] rr_last, rr_n, win, idx, sel_n;
    logic [3:0] grant_n;
    always_comb begin
        win = 2'd0;
        idx = 2'd0;
        // descending scan so the candidate nearest after rr_last is written last
        for (int i = 4; i >= 1; i--) begin
            idx = rr_last + 2'(i);
            if (bus.req[idx]) win = idx;
        end
        state_n = state;
        cnt_n   = (cnt != '0) ? cnt - 1'b1 : cnt;
        grant_n = bus.grant;
        sel_n   = {bus.sel_b, bus.sel_a};
        rr_n    = rr_last;
        case (state)
            IDLE: if (|bus.req) begin
                state_n = (SETUP_CYC > 0) ? SETUP : STROBE;
                cnt_n   = (SETUP_CYC > 0) ? SETUP_LD : STROBE_LD;
                grant_n = 4'b0001 << win;
                sel_n   = win;
                rr_n    = win;
            end
            SETUP: if (cnt == '0) begin
                state_n = STROBE;
                cnt_n   = STROBE_LD;
            end
            STROBE: if (cnt == '0) begin
                state_n = (HOLD_CYC > 0) ? HOLD : IDLE;
                cnt_n   = HOLD_LD;
            end
            default: if (cnt == '0) state_n = IDLE;
        endcase
        if (state_n == IDLE) begin
            grant_n = '0;
            sel_n   = '0;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rr_last     <= 2'd3;
            bus.grant   <= '0;
            bus.ack     <= '0;
            bus.busy    <= 1'b0;
            bus.sel_a   <= 1'b0;
            bus.sel_b   <= 1'b0;
            bus.sel_g_n <= 1'b1;
        end else begin
            state                <= state_n;
            cnt                  <= cnt_n;
            rr_last              <= rr_n;
            bus.grant            <= grant_n;
            bus.ack              <= (state != IDLE && state_n == IDLE) ? bus.grant : 4'b0000;
            bus.busy             <= state_n != IDLE;
            {bus.sel_b, bus.sel_a} <= sel_n;
            bus.sel_g_n          <= state_n != STROBE;
        end
    end
endmodule
